// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with a bounded hold time.
// Drives a one-hot grant plus the matching 4:1 mux select; every output is registered.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic       dbg_state
);

  // Handshake: a requester raises REQ[i] and holds it for as long as it wants the
  // path. GNT[i] rises one cycle after the request is arbitrated. Ownership ends at
  // the first clock edge that sees any of these: DONE high, REQ[i] low, or the hold
  // limit reached. The arbiter always spends one cycle in IDLE before the next grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  logic [1:0] win_idx;
  logic       win_found;
  logic [1:0] cand;
  logic       hold_limit;
  logic       req_drop;
  logic       release_now;

  assign dbg_state = state;

  // Search for the first active request, starting at ptr and wrapping modulo 4.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!win_found && REQ[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign hold_limit  = (hold_cnt == HOLD_LAST);
  assign req_drop    = !REQ[SEL];
  assign release_now = DONE || req_drop || hold_limit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      GNT      <= 4'b0000;
      SEL      <= 2'd0;
      BUSY     <= 1'b0;
      TIMEOUT  <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          TIMEOUT <= 1'b0;
          if (win_found) begin
            state    <= GRANT;
            GNT      <= 4'b0001 << win_idx;
            SEL      <= win_idx;
            BUSY     <= 1'b1;
            hold_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            GNT      <= 4'b0000;
            BUSY     <= 1'b0;
            ptr      <= SEL + 2'd1;
            hold_cnt <= 8'd0;
            // The timeout pulse is raised only when the hold limit alone ends the grant.
            TIMEOUT  <= hold_limit && !DONE && !req_drop;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= 4'b0000;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 (MAX_HOLD = 4); expected values are computed by hand.
module tb_bus_arbiter4;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       BUSY;
  logic       TIMEOUT;
  logic       dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  bus_arbiter4 #(.MAX_HOLD(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .DONE      (DONE),
    .GNT       (GNT),
    .SEL       (SEL),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 ns later; BUSY must always mirror OR of GNT.
  task automatic step();
    @(posedge CLK);
    #1;
    chk("busy_or_gnt", {7'd0, BUSY}, {7'd0, |GNT});
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] s);
    chk({tag, "_gnt"}, {4'd0, GNT}, {4'd0, g});
    chk({tag, "_sel"}, {6'd0, SEL}, {6'd0, s});
  endtask

  initial begin
    RST  = 1'b1;
    REQ  = 4'b0000;
    DONE = 1'b0;
    repeat (2) step();
    chk("rst_gnt",     {4'd0, GNT}, 8'h00);
    chk("rst_sel",     {6'd0, SEL}, 8'h00);
    chk("rst_busy",    {7'd0, BUSY}, 8'h00);
    chk("rst_timeout", {7'd0, TIMEOUT}, 8'h00);

    // First arbitration from pointer 0: requester 1 wins over 3.
    RST = 1'b0;
    REQ = 4'b1010;
    step();
    chk_grant("first", 4'b0010, 2'd1);
    chk("first_busy", {7'd0, BUSY}, 8'h01);

    // DONE releases; pointer moves to 2, so requester 3 wins next.
    DONE = 1'b1;
    step();
    chk_grant("done_rel", 4'b0000, 2'd1);
    chk("done_rel_to", {7'd0, TIMEOUT}, 8'h00);
    DONE = 1'b0;
    step();
    chk_grant("rr_next", 4'b1000, 2'd3);

    // Other requesters changing during a grant do not disturb it.
    REQ = 4'b1111;
    step();
    chk_grant("hold_other", 4'b1000, 2'd3);
    DONE = 1'b1;
    step();
    chk_grant("rel3", 4'b0000, 2'd3);
    DONE = 1'b0;

    // Full rotation with all requesters active: 0,1,2,3,0 with an idle cycle between.
    for (int k = 0; k < 5; k++) begin
      step();
      chk_grant($sformatf("rot%0d", k), 4'b0001 << (k % 4), 2'(k % 4));
      DONE = 1'b1;
      step();
      chk($sformatf("rot%0d_idle", k), {7'd0, BUSY}, 8'h00);
      DONE = 1'b0;
    end

    // DONE while idle has no effect.
    REQ  = 4'b0000;
    DONE = 1'b1;
    step();
    chk("idle_done_busy", {7'd0, BUSY}, 8'h00);
    chk("idle_done_to",   {7'd0, TIMEOUT}, 8'h00);
    DONE = 1'b0;

    // Hold limit: pointer is 1, requester 2 holds for exactly 4 cycles.
    REQ = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_grant($sformatf("hold_c%0d", c), 4'b0100, 2'd2);
      chk($sformatf("hold_c%0d_to", c), {7'd0, TIMEOUT}, 8'h00);
    end
    step();
    chk_grant("limit_rel", 4'b0000, 2'd2);
    chk("limit_to", {7'd0, TIMEOUT}, 8'h01);
    REQ = 4'b0000;
    step();
    chk("limit_to_pulse", {7'd0, TIMEOUT}, 8'h00);

    // DONE on the 4th grant cycle suppresses the timeout pulse.
    REQ = 4'b0100;
    repeat (4) step();
    chk_grant("done4_pre", 4'b0100, 2'd2);
    DONE = 1'b1;
    step();
    chk_grant("done4_rel", 4'b0000, 2'd2);
    chk("done4_to", {7'd0, TIMEOUT}, 8'h00);
    DONE = 1'b0;
    REQ  = 4'b0000;
    step();

    // REQ dropped on the 4th grant cycle also suppresses the timeout pulse.
    REQ = 4'b0100;
    repeat (4) step();
    chk_grant("drop4_pre", 4'b0100, 2'd2);
    REQ = 4'b0000;
    step();
    chk_grant("drop4_rel", 4'b0000, 2'd2);
    chk("drop4_to", {7'd0, TIMEOUT}, 8'h00);

    // Async reset mid-grant to requester 3 (pointer is 3).
    REQ = 4'b1000;
    step();
    chk_grant("pre_rst", 4'b1000, 2'd3);
    #2;
    RST = 1'b1;
    #1;
    chk_grant("async_rst", 4'b0000, 2'd0);
    chk("async_rst_busy", {7'd0, BUSY}, 8'h00);
    step();
    chk("rst_no_to", {7'd0, TIMEOUT}, 8'h00);
    RST = 1'b0;
    REQ = 4'b1001;
    step();
    chk_grant("post_rst", 4'b0001, 2'd0);

    // Dropping the granted request releases without a timeout pulse.
    REQ = 4'b1000;
    step();
    chk_grant("reqdrop_rel", 4'b0000, 2'd0);
    chk("reqdrop_to", {7'd0, TIMEOUT}, 8'h00);
    step();
    chk_grant("reqdrop_next", 4'b1000, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum grant length in cycles before forced release; legal range 2..256.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous and active-high.
REQ-004 Port: REQ  input  4  per-requester request; bit i = requester i wants the shared 4:1 mux path.
REQ-005 Port: DONE  input  1  current grant holder finished; sampled only while a grant is active.
REQ-006 Port: GNT  output  4  one-hot grant, or all-zero when idle.
REQ-007 Port: SEL  output  2  index of granted requester, wired to the 4:1 mux select.
REQ-008 Port: BUSY  output  1  high while any grant is active; equals OR of GNT.
REQ-009 Port: TIMEOUT  output  1  single-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-010 Two states: IDLE, GRANT; all outputs driven from registers, no combinational REQ-to-GNT path.
REQ-011 IDLE, REQ != 0 at edge N: after edge N, state = GRANT, GNT = one-hot of winner, SEL = winner index, BUSY = 1; one-cycle grant latency.
REQ-012 Winner = first set REQ bit scanning upward from round-robin pointer PTR, wrapping 3 -> 0.
REQ-013 IDLE, REQ == 0: remain IDLE; GNT = 0, BUSY = 0; SEL holds last granted index (mux input stable).
REQ-014 GRANT: 8-bit hold counter cleared on grant entry, incremented each GRANT cycle.
REQ-015 Release from GRANT at edge when any of: DONE = 1; REQ[SEL] = 0; hold counter = MAX_HOLD-1.
REQ-016 On release: state -> IDLE, GNT = 0, BUSY = 0, PTR = (SEL+1) mod 4; grant therefore lasts at most MAX_HOLD cycles.
REQ-017 Exactly one idle cycle between consecutive grants; no back-to-back grant in the release cycle.
REQ-018 TIMEOUT = 1 for the one cycle after a release caused only by the hold limit; DONE or REQ drop in the same cycle as the limit suppresses TIMEOUT.
REQ-019 REQ changes of non-granted requesters during GRANT have no effect on GNT/SEL.
REQ-020 DONE while IDLE ignored.
REQ-021 All four REQ held continuously: grants rotate 0,1,2,3,0,... each requester serviced within 4 grant periods (starvation-free).
REQ-022 GNT always one-hot or zero; SEL always equals the index of the GNT bit when BUSY = 1.

Reset
REQ-023 RST = 1 asynchronously forces: state IDLE, GNT = 0, SEL = 0, BUSY = 0, TIMEOUT = 0, PTR = 0, hold counter = 0.
REQ-024 RST asserted mid-grant drops GNT immediately, without waiting for a clock edge; no TIMEOUT pulse generated.
REQ-025 First arbitration after reset deassertion favours requester 0.

Verification
REQ-026 Reset, then REQ = 4'b1010 at edge 1 -> after edge 1: GNT = 4'b0010, SEL = 1, BUSY = 1.
REQ-027 Grant to requester 1, DONE = 1 for one cycle -> next cycle GNT = 0, BUSY = 0, TIMEOUT = 0; REQ = 4'b1010 still high -> following cycle GNT = 4'b1000, SEL = 3.
REQ-028 MAX_HOLD = 4, requester 2 holds REQ with DONE = 0 -> GNT = 4'b0100 for exactly 4 cycles, then GNT = 0 with TIMEOUT = 1 for one cycle.
REQ-029 REQ = 4'b1111 held, DONE pulsed each grant -> SEL sequence 0,1,2,3,0 with one idle cycle between grants.
REQ-030 RST pulsed during grant to requester 3 -> GNT = 0, SEL = 0 before next edge; after release, REQ = 4'b1001 -> grant to requester 0.
REQ-031 MAX_HOLD = 4, DONE = 1 on the 4th grant cycle -> release with TIMEOUT = 0.
